// File: rtl/game_input_frontend.sv
// game_input_frontend: synchronises and debounces the four game buttons into CEN-aligned
// one-shot strobes, and captures the switch value presented with each Select.
module game_input_frontend #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W = 20
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       CEN,
    input  logic       BtnC_raw,
    input  logic       BtnD_raw,
    input  logic       BtnL_raw,
    input  logic       BtnR_raw,
    input  logic [7:0] Sw_raw,
    output logic       Select,
    output logic       Quit,
    output logic       selectLeft,
    output logic       selectRight,
    output logic [7:0] userNumber
);
    typedef enum logic [5:0] {
        IDLE   = 6'b000001,
        WAIT_P = 6'b000010,
        ARM    = 6'b000100,
        PEND   = 6'b001000,
        HELD   = 6'b010000,
        WAIT_R = 6'b100000
    } state_t;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    logic [11:0] s1, s2;
    state_t st [4];
    state_t st_n [4];
    logic [CNT_W-1:0] cnt [4];
    logic [CNT_W-1:0] cnt_n [4];
    logic [3:0] pend, go;
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= {Sw_raw, BtnR_raw, BtnL_raw, BtnD_raw, BtnC_raw};
            s2 <= s1;
        end
    end
    always_comb begin
        for (int i = 0; i < 4; i++) pend[i] = st[i] == PEND;
    end
    // index 0=C 1=D 2=L 3=R; a pending button waits while any higher-priority one is pending
    assign Quit        = CEN & pend[1];
    assign Select      = CEN & pend[0] & ~pend[1];
    assign selectLeft  = CEN & pend[2] & ~pend[1] & ~pend[0];
    assign selectRight = CEN & pend[3] & ~|pend[2:0];
    assign go = {selectRight, selectLeft, Quit, Select};
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            st_n[i] = st[i];
            cnt_n[i] = cnt[i];
            case (st[i])
                IDLE: if (s2[i]) begin
                    st_n[i] = WAIT_P;
                    cnt_n[i] = '0;
                end
                WAIT_P: if (!s2[i]) st_n[i] = IDLE;
                    else if (cnt[i] == LAST) st_n[i] = ARM;
                    else cnt_n[i] = cnt[i] + 1'b1;
                ARM: st_n[i] = PEND;
                PEND: if (go[i]) st_n[i] = HELD;
                HELD: if (!s2[i]) begin
                    st_n[i] = WAIT_R;
                    cnt_n[i] = '0;
                end
                WAIT_R: if (s2[i]) st_n[i] = HELD;
                    else if (cnt[i] == LAST) st_n[i] = IDLE;
                    else cnt_n[i] = cnt[i] + 1'b1;
                default: st_n[i] = IDLE;
            endcase
        end
    end
    // switches are latched on the edge into ARM so userNumber leads Select by a cycle
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < 4; i++) begin
                st[i] <= IDLE;
                cnt[i] <= '0;
            end
            userNumber <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                st[i] <= st_n[i];
                cnt[i] <= cnt_n[i];
            end
            if (st[0] == WAIT_P && s2[0] && cnt[0] == LAST) userNumber <= s2[11:4];
        end
    end
endmodule

// File: tb/tb_game_input_frontend.sv
// tb_game_input_frontend: run-length reference model of the button front end, checked every
// cycle, plus directed scenarios with literal timing/count expectations and a random soak.
module tb_game_input_frontend;
    localparam int D = 4;
    logic       clk = 0;
    logic       Reset = 1;
    logic       CEN = 1;
    logic       BtnC = 0, BtnD = 0, BtnL = 0, BtnR = 0;
    logic [7:0] Sw = 0;
    logic       Select, Quit, selectLeft, selectRight;
    logic [7:0] userNumber;
    int pass_n = 0, tot_n = 0;
    int cyc = 0;
    int cen_mode = 0;
    int mode [4];
    int ones [4];
    int zeros [4];
    int pri [4] = '{1, 0, 2, 3};
    logic [11:0] m_s1 = 0, m_s2 = 0;
    logic [7:0] m_un = 0;
    int s_cnt = 0, q_cnt = 0, l_cnt = 0, r_cnt = 0, multi = 0;
    int s_cyc = 0, q_cyc = 0;
    logic [7:0] un_last = 0, s_un_prev = 0;
    logic r_cen = 0;

    game_input_frontend #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
        .Clk(clk), .Reset(Reset), .CEN(CEN),
        .BtnC_raw(BtnC), .BtnD_raw(BtnD), .BtnL_raw(BtnL), .BtnR_raw(BtnR),
        .Sw_raw(Sw), .Select(Select), .Quit(Quit), .selectLeft(selectLeft),
        .selectRight(selectRight), .userNumber(userNumber)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tot_n++;
        if (act === exp) pass_n++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Model: 0 released (counting 1s), 1 qualified (capture cycle), 2 pending, 3 held (counting 0s)
    always @(posedge clk) begin : model
        int g;
        logic b;
        cyc++;
        if (Reset) begin
            m_s1 = 0;
            m_s2 = 0;
            m_un = 0;
            for (int i = 0; i < 4; i++) begin
                mode[i] = 0;
                ones[i] = 0;
                zeros[i] = 0;
            end
        end else begin
            g = -1;
            for (int k = 0; k < 4; k++)
                if (g < 0 && mode[pri[k]] == 2 && CEN) g = pri[k];
            for (int i = 0; i < 4; i++) begin
                b = m_s2[i];
                case (mode[i])
                    0: begin
                        ones[i] = b ? ones[i] + 1 : 0;
                        if (ones[i] == D + 1) begin
                            mode[i] = 1;
                            ones[i] = 0;
                            if (i == 0) m_un = m_s2[11:4];
                        end
                    end
                    1: mode[i] = 2;
                    2: if (g == i) begin
                        mode[i] = 3;
                        zeros[i] = 0;
                    end
                    default: begin
                        zeros[i] = b ? 0 : zeros[i] + 1;
                        if (zeros[i] == D + 1) begin
                            mode[i] = 0;
                            ones[i] = 0;
                        end
                    end
                endcase
            end
            m_s2 = m_s1;
            m_s1 = {Sw, BtnR, BtnL, BtnD, BtnC};
        end
    end

    always @(negedge clk) begin : compare
        logic [3:0] es, dv;
        es = 0;
        dv = {selectRight, selectLeft, Quit, Select};
        if (!Reset)
            for (int k = 0; k < 4; k++)
                if (es == 0 && mode[pri[k]] == 2 && CEN) es[pri[k]] = 1'b1;
        chk("strobes", {28'd0, dv}, {28'd0, es});
        chk("userNumber", {24'd0, userNumber}, {24'd0, Reset ? 8'h00 : m_un});
        if ($countones(dv) > 1) multi++;
        if (Select) begin
            s_cnt++;
            s_cyc = cyc;
            s_un_prev = un_last;
        end
        if (Quit) begin
            q_cnt++;
            q_cyc = cyc;
        end
        if (selectLeft) l_cnt++;
        if (selectRight) begin
            r_cnt++;
            r_cen = CEN;
        end
        un_last = userNumber;
    end

    initial begin : cen_drv
        forever begin
            @(posedge clk);
            #1;
            CEN = cen_mode == 0 ? 1'b1 : cen_mode == 1 ? (cyc % 5 == 0) :
                  cen_mode == 2 ? 1'($urandom % 2) : 1'b0;
        end
    end

    initial begin : main
        int t0, c0, c1;
        logic b2 [5] = '{1, 0, 1, 1, 0};
        logic [3:0] b;
        step(3);
        chk("reset_un", {24'd0, userNumber}, 0);
        chk("reset_strobes", {28'd0, Select, Quit, selectLeft, selectRight}, 0);
        Reset = 0;
        step(2);
        // 1: clean centre press, latency and capture
        Sw = 8'hA5;
        c0 = s_cnt;
        t0 = cyc;
        BtnC = 1;
        step(20);
        chk("t1_count", s_cnt - c0, 1);
        chk("t1_latency", s_cyc - t0, 8);
        chk("t1_un_before", {24'd0, s_un_prev}, 32'hA5);
        BtnC = 0;
        step(10);
        // 2: bouncing left button
        c0 = l_cnt;
        for (int i = 0; i < 5; i++) begin
            BtnL = b2[i];
            step(1);
        end
        chk("t2_bounce", l_cnt - c0, 0);
        BtnL = 1;
        step(15);
        chk("t2_count", l_cnt - c0, 1);
        BtnL = 0;
        step(10);
        // 3: sparse CEN
        cen_mode = 1;
        c0 = r_cnt;
        BtnR = 1;
        step(30);
        chk("t3_count", r_cnt - c0, 1);
        chk("t3_cen", {31'd0, r_cen}, 1);
        BtnR = 0;
        step(15);
        cen_mode = 0;
        step(2);
        // 4: simultaneous down and centre
        c0 = q_cnt;
        c1 = s_cnt;
        BtnD = 1;
        BtnC = 1;
        step(15);
        chk("t4_quit", q_cnt - c0, 1);
        chk("t4_select", s_cnt - c1, 1);
        chk("t4_order", s_cyc - q_cyc, 1);
        BtnD = 0;
        BtnC = 0;
        step(10);
        // 5: switch motion after capture
        Sw = 8'h3C;
        BtnC = 1;
        step(12);
        BtnC = 0;
        step(10);
        Sw = 8'hFF;
        step(10);
        chk("t5_un", {24'd0, userNumber}, 32'h3C);
        // 6: reset during debounce and during pending
        c0 = s_cnt;
        BtnC = 1;
        step(4);
        Reset = 1;
        step(1);
        chk("t6_rst_un", {24'd0, userNumber}, 0);
        Reset = 0;
        step(15);
        chk("t6_requal", s_cnt - c0, 1);
        BtnC = 0;
        step(10);
        cen_mode = 3;
        c0 = q_cnt;
        BtnD = 1;
        step(12);
        chk("t6_no_cen", q_cnt - c0, 0);
        Reset = 1;
        step(1);
        Reset = 0;
        cen_mode = 0;
        step(15);
        chk("t6_pend_requal", q_cnt - c0, 1);
        BtnD = 0;
        step(10);
        // random soak
        cen_mode = 2;
        b = 0;
        repeat (3000) begin
            for (int k = 0; k < 4; k++) if ($urandom % 8 == 0) b[k] = ~b[k];
            {BtnR, BtnL, BtnD, BtnC} = b;
            if ($urandom % 16 == 0) Sw = 8'($urandom);
            Reset = $urandom % 400 == 0;
            step(1);
        end
        Reset = 0;
        cen_mode = 0;
        {BtnR, BtnL, BtnD, BtnC} = 0;
        step(20);
        chk("no_multi", multi, 0);
        $display("%0d/%0d checks passed", pass_n, tot_n);
        $finish;
    end
endmodule
